// File: rtl/interrupt_priority_sequencer_if.sv
// Signal bundle between the interrupt sequencer, the request/mask registers and the CPU acknowledge path.
// master drives requests, INTA and EOI commands; slave is the sequencer.
interface interrupt_priority_sequencer_if;
  logic [7:0] Int_Req_Reg;
  logic [7:0] Int_Mask_Reg;
  logic       inta_n;
  logic       eoi;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       auto_eoi;
  logic [4:0] vector_base;
  logic       int_out;
  logic [7:0] Int_Serv_Reg;
  logic [7:0] clear_irr;
  logic [7:0] data_out;
  logic       data_out_en;

  modport master (
    output Int_Req_Reg, Int_Mask_Reg, inta_n, eoi, eoi_specific, eoi_level, auto_eoi, vector_base,
    input  int_out, Int_Serv_Reg, clear_irr, data_out, data_out_en
  );

  modport slave (
    input  Int_Req_Reg, Int_Mask_Reg, inta_n, eoi, eoi_specific, eoi_level, auto_eoi, vector_base,
    output int_out, Int_Serv_Reg, clear_irr, data_out, data_out_en
  );
endinterface

// File: rtl/interrupt_priority_sequencer.sv
// Interrupt priority sequencer: masks requests, resolves priority against the ISR and runs the INTA/EOI handshake.
// Optional macro ROTATE_PRIORITY_EN replaces fixed IR0-highest priority with a rotating lowest-priority pointer.
module interrupt_priority_sequencer #(
  parameter int NUM_IR         = 8,
  parameter int SPURIOUS_LEVEL = 7
) (
  input logic                           clk,
  input logic                           reset,
  interrupt_priority_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, PEND, ACK1, WAIT2, ACK2} state_t;

  localparam logic [7:0] ONE_HOT = 8'd1;

  state_t     state_q, state_d;
  logic       int_out_q, int_out_d;
  logic [7:0] isr_q, isr_d;
  logic [7:0] clear_q, clear_d;
  logic [7:0] data_q, data_d;
  logic       data_en_q, data_en_d;
  logic [2:0] level_q, level_d;
  logic       spurious_q, spurious_d;
  logic       prev_inta_n_q;

  logic       inta_fall, inta_rise;
  logic [2:0] prio_base;
  logic [7:0] eff, rot_eff, rot_isr;
  logic       eff_found, isr_found, win_valid;
  logic [2:0] eff_rank, isr_rank, win_level, top_isr_level;
  logic [7:0] set_mask, retire_mask, eoi_mask;

  // prio_base is the level holding the highest priority; everything below works in rank space.
`ifdef ROTATE_PRIORITY_EN
  logic [2:0] prio_ptr_q, prio_ptr_d;
  assign prio_base = prio_ptr_q + 3'd1;
`else
  assign prio_base = 3'd0;
`endif

  assign eff       = bus.Int_Req_Reg & ~bus.Int_Mask_Reg;
  assign inta_fall = prev_inta_n_q & ~bus.inta_n;
  assign inta_rise = ~prev_inta_n_q & bus.inta_n;

  always_comb begin
    rot_eff = '0;
    rot_isr = '0;
    for (int j = 0; j < NUM_IR; j++) begin
      rot_eff[j] = eff[prio_base + 3'(j)];
      rot_isr[j] = isr_q[prio_base + 3'(j)];
    end
  end

  always_comb begin
    eff_found = 1'b0;
    eff_rank  = '0;
    isr_found = 1'b0;
    isr_rank  = '0;
    for (int j = NUM_IR - 1; j >= 0; j--) begin
      if (rot_eff[j]) begin
        eff_found = 1'b1;
        eff_rank  = 3'(j);
      end
      if (rot_isr[j]) begin
        isr_found = 1'b1;
        isr_rank  = 3'(j);
      end
    end
  end

  // A request only wins if it outranks every level already in service.
  assign win_valid     = eff_found && (!isr_found || (eff_rank < isr_rank));
  assign win_level     = prio_base + eff_rank;
  assign top_isr_level = prio_base + isr_rank;

  always_comb begin
    state_d     = state_q;
    int_out_d   = int_out_q;
    clear_d     = '0;
    data_d      = data_q;
    data_en_d   = data_en_q;
    level_d     = level_q;
    spurious_d  = spurious_q;
    set_mask    = '0;
    retire_mask = '0;
    eoi_mask    = '0;

    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d   = PEND;
          int_out_d = 1'b1;
        end
      end
      PEND: begin
        if (inta_fall) begin
          state_d   = ACK1;
          int_out_d = 1'b0;
          if (win_valid) begin
            level_d    = win_level;
            spurious_d = 1'b0;
            set_mask   = ONE_HOT << win_level;
            clear_d    = ONE_HOT << win_level;
          end else begin
            level_d    = 3'(SPURIOUS_LEVEL);
            spurious_d = 1'b1;
          end
        end
      end
      ACK1: begin
        if (inta_rise) state_d = WAIT2;
      end
      WAIT2: begin
        if (inta_fall) begin
          state_d   = ACK2;
          data_d    = {bus.vector_base, level_q};
          data_en_d = 1'b1;
        end
      end
      ACK2: begin
        if (inta_rise) begin
          state_d   = IDLE;
          data_en_d = 1'b0;
          if (bus.auto_eoi && !spurious_q) retire_mask = ONE_HOT << level_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.eoi) begin
      if (bus.eoi_specific) eoi_mask = ONE_HOT << bus.eoi_level;
      else if (isr_found)   eoi_mask = ONE_HOT << top_isr_level;
    end

    // Set is applied last so a same-cycle set and clear of one bit leaves it set.
    isr_d = (isr_q & ~(eoi_mask | retire_mask)) | set_mask;
  end

`ifdef ROTATE_PRIORITY_EN
  always_comb begin
    prio_ptr_d = prio_ptr_q;
    if ((retire_mask & isr_q) != '0) prio_ptr_d = level_q;
    if ((eoi_mask & isr_q) != '0)    prio_ptr_d = bus.eoi_specific ? bus.eoi_level : top_isr_level;
  end

  always_ff @(posedge clk) begin
    if (reset) prio_ptr_q <= 3'd7;
    else       prio_ptr_q <= prio_ptr_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      int_out_q     <= 1'b0;
      isr_q         <= '0;
      clear_q       <= '0;
      data_q        <= '0;
      data_en_q     <= 1'b0;
      level_q       <= '0;
      spurious_q    <= 1'b0;
      prev_inta_n_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      int_out_q     <= int_out_d;
      isr_q         <= isr_d;
      clear_q       <= clear_d;
      data_q        <= data_d;
      data_en_q     <= data_en_d;
      level_q       <= level_d;
      spurious_q    <= spurious_d;
      prev_inta_n_q <= bus.inta_n;
    end
  end

  assign bus.int_out      = int_out_q;
  assign bus.Int_Serv_Reg = isr_q;
  assign bus.clear_irr    = clear_q;
  assign bus.data_out     = data_q;
  assign bus.data_out_en  = data_en_q;

endmodule

// File: tb/tb_interrupt_priority_sequencer.sv
// Bench for interrupt_priority_sequencer: directed INTA/EOI scenarios, a rank-based reference model
// compared every cycle, plus literal expectations at key points.
module tb_interrupt_priority_sequencer;

  logic clk = 1'b0;
  logic reset;

  interrupt_priority_sequencer_if bus_if ();

  interrupt_priority_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;
  bit chk_en       = 1'b0;

  bit         m_isr[8];
  bit         m_int;
  logic [7:0] m_clr;
  logic [7:0] m_data;
  bit         m_den;
  bit         m_prev_inta;
  logic [2:0] m_level;
  bit         m_spur;
  int         m_stage;
  int         m_ptr;

  logic [7:0] vec, clr, mid;

  task automatic compare(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s @%0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_isr[i]) m_isr[i] = 1'b0;
    m_int       = 1'b0;
    m_clr       = '0;
    m_data      = '0;
    m_den       = 1'b0;
    m_prev_inta = 1'b1;
    m_level     = '0;
    m_spur      = 1'b0;
    m_stage     = 0;
    m_ptr       = 7;
  endtask

  function automatic logic [7:0] model_isr_packed();
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i] = m_isr[i];
    return v;
  endfunction

  // Levels are visited in priority order starting one past the lowest-priority pointer.
  function automatic int model_top_isr();
    for (int r = 0; r < 8; r++) begin
      int l;
      l = (m_ptr + 1 + r) % 8;
      if (m_isr[l]) return l;
    end
    return -1;
  endfunction

  function automatic int model_winner();
    int isr_rank;
    isr_rank = 8;
    for (int r = 7; r >= 0; r--)
      if (m_isr[(m_ptr + 1 + r) % 8]) isr_rank = r;
    for (int r = 0; r < isr_rank; r++) begin
      int l;
      l = (m_ptr + 1 + r) % 8;
      if (bus_if.Int_Req_Reg[l] && !bus_if.Int_Mask_Reg[l]) return l;
    end
    return -1;
  endfunction

  // m_stage counts progress through the handshake: 0 idle, 1 requesting, 2 first INTA, 3 between, 4 second INTA.
  task automatic model_step();
    bit fall, rise;
    int w, eoi_lvl, ret_lvl, set_lvl;
    if (reset) begin
      model_reset();
      return;
    end
    fall        = m_prev_inta && !bus_if.inta_n;
    rise        = !m_prev_inta && bus_if.inta_n;
    m_prev_inta = bus_if.inta_n;
    w       = model_winner();
    eoi_lvl = -1;
    ret_lvl = -1;
    set_lvl = -1;
    m_clr   = '0;
    case (m_stage)
      0: if (w >= 0) begin m_stage = 1; m_int = 1'b1; end
      1: if (fall) begin
           m_stage = 2;
           m_int   = 1'b0;
           if (w >= 0) begin
             m_level  = 3'(w);
             m_spur   = 1'b0;
             set_lvl  = w;
             m_clr[w] = 1'b1;
           end else begin
             m_level = 3'd7;
             m_spur  = 1'b1;
           end
         end
      2: if (rise) m_stage = 3;
      3: if (fall) begin m_stage = 4; m_den = 1'b1; m_data = {bus_if.vector_base, m_level}; end
      4: if (rise) begin
           m_stage = 0;
           m_den   = 1'b0;
           if (bus_if.auto_eoi && !m_spur) ret_lvl = int'(m_level);
         end
      default: ;
    endcase
    if (bus_if.eoi) eoi_lvl = bus_if.eoi_specific ? int'(bus_if.eoi_level) : model_top_isr();
`ifdef ROTATE_PRIORITY_EN
    if (ret_lvl >= 0 && m_isr[ret_lvl]) m_ptr = ret_lvl;
    if (eoi_lvl >= 0 && m_isr[eoi_lvl]) m_ptr = eoi_lvl;
`endif
    if (ret_lvl >= 0) m_isr[ret_lvl] = 1'b0;
    if (eoi_lvl >= 0) m_isr[eoi_lvl] = 1'b0;
    if (set_lvl >= 0) m_isr[set_lvl] = 1'b1;
  endtask

  task automatic check_output();
    compare("int_out",      8'(bus_if.int_out),     8'(m_int));
    compare("Int_Serv_Reg", bus_if.Int_Serv_Reg,    model_isr_packed());
    compare("clear_irr",    bus_if.clear_irr,       m_clr);
    compare("data_out",     bus_if.data_out,        m_data);
    compare("data_out_en",  8'(bus_if.data_out_en), 8'(m_den));
  endtask

  always @(negedge clk) if (chk_en) check_output();

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic apply_stimulus(input logic [7:0] req, input logic [7:0] mask, input int cycles);
    bus_if.Int_Req_Reg  = req;
    bus_if.Int_Mask_Reg = mask;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic send_eoi(input bit specific, input logic [2:0] level);
    bus_if.eoi          = 1'b1;
    bus_if.eoi_specific = specific;
    bus_if.eoi_level    = level;
    tick();
    bus_if.eoi          = 1'b0;
  endtask

  // Two INTA pulses; the request register drops the acknowledged bit as clear_irr would make it.
  task automatic run_ack(output logic [7:0] vec_o, output logic [7:0] clr_o, output logic [7:0] isr_o);
    bus_if.inta_n = 1'b0;
    tick();
    clr_o = bus_if.clear_irr;
    bus_if.Int_Req_Reg = bus_if.Int_Req_Reg & ~m_clr;
    tick();
    bus_if.inta_n = 1'b1;
    tick();
    tick();
    bus_if.inta_n = 1'b0;
    tick();
    vec_o = bus_if.data_out;
    isr_o = bus_if.Int_Serv_Reg;
    tick();
    bus_if.inta_n = 1'b1;
    tick();
  endtask

  initial begin
    reset               = 1'b1;
    bus_if.Int_Req_Reg  = '0;
    bus_if.Int_Mask_Reg = '0;
    bus_if.inta_n       = 1'b1;
    bus_if.eoi          = 1'b0;
    bus_if.eoi_specific = 1'b0;
    bus_if.eoi_level    = '0;
    bus_if.auto_eoi     = 1'b0;
    bus_if.vector_base  = 5'h11;
    model_reset();
    tick();
    tick();
    compare("reset_int_out", 8'(bus_if.int_out), 8'h00);
    compare("reset_isr",     bus_if.Int_Serv_Reg, 8'h00);
    compare("reset_den",     8'(bus_if.data_out_en), 8'h00);
    compare("reset_data",    bus_if.data_out, 8'h00);
    chk_en = 1'b1;
    reset  = 1'b0;

    $display("[TB] single request");
    apply_stimulus(8'h08, 8'h00, 1);
    compare("t1_int_out", 8'(bus_if.int_out), 8'h01);
    run_ack(vec, clr, mid);
    compare("t1_clear_irr", clr, 8'h08);
    compare("t1_isr",       mid, 8'h08);
    compare("t1_vector",    vec, 8'h8B);
    compare("t1_den_low",   8'(bus_if.data_out_en), 8'h00);
    compare("t1_data_held", bus_if.data_out, 8'h8B);

    $display("[TB] priority, mask and nesting");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    compare("t2_isr_cleared", bus_if.Int_Serv_Reg, 8'h00);
    apply_stimulus(8'h24, 8'h04, 1);
    compare("t2_int_out", 8'(bus_if.int_out), 8'h01);
    run_ack(vec, clr, mid);
    compare("t2_vector5", vec, 8'h8D);
    compare("t2_clear5",  clr, 8'h20);
    compare("t2_isr5",    mid, 8'h20);
    apply_stimulus(8'h64, 8'h04, 2);
    compare("t2_blocked", 8'(bus_if.int_out), 8'h00);
    apply_stimulus(8'h06, 8'h04, 1);
    compare("t2_nest_int", 8'(bus_if.int_out), 8'h01);
    compare("t2_nest_isr", bus_if.Int_Serv_Reg, 8'h20);
    run_ack(vec, clr, mid);
    compare("t2_vector1", vec, 8'h89);
    compare("t2_clear1",  clr, 8'h02);
    compare("t2_isr22",   bus_if.Int_Serv_Reg, 8'h22);

    $display("[TB] EOI");
    send_eoi(1'b0, 3'd0);
    compare("t3_nonspec", bus_if.Int_Serv_Reg, 8'h20);
    send_eoi(1'b1, 3'd5);
    compare("t3_spec5",   bus_if.Int_Serv_Reg, 8'h00);
    send_eoi(1'b0, 3'd0);
    compare("t3_empty",   bus_if.Int_Serv_Reg, 8'h00);

    $display("[TB] spurious and auto-EOI");
    apply_stimulus(8'h10, 8'h00, 1);
    compare("t4_int_out", 8'(bus_if.int_out), 8'h01);
    apply_stimulus(8'h00, 8'h00, 1);
    compare("t4_int_held", 8'(bus_if.int_out), 8'h01);
    run_ack(vec, clr, mid);
    compare("t4_spur_clear",  clr, 8'h00);
    compare("t4_spur_isr",    mid, 8'h00);
    compare("t4_spur_vector", vec, 8'h8F);
    bus_if.auto_eoi = 1'b1;
    apply_stimulus(8'h08, 8'h00, 1);
    run_ack(vec, clr, mid);
    compare("t4_aeoi_mid",    mid, 8'h08);
    compare("t4_aeoi_vector", vec, 8'h8B);
    compare("t4_aeoi_isr",    bus_if.Int_Serv_Reg, 8'h00);
    bus_if.auto_eoi = 1'b0;

    $display("[TB] reset mid-sequence");
    apply_stimulus(8'h02, 8'h00, 1);
    bus_if.inta_n = 1'b0;
    tick();
    bus_if.Int_Req_Reg = 8'h00;
    tick();
    bus_if.inta_n = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    compare("t5_int_out", 8'(bus_if.int_out), 8'h00);
    compare("t5_isr",     bus_if.Int_Serv_Reg, 8'h00);
    compare("t5_clear",   bus_if.clear_irr, 8'h00);
    compare("t5_data",    bus_if.data_out, 8'h00);
    compare("t5_den",     8'(bus_if.data_out_en), 8'h00);
    reset = 1'b0;
    bus_if.inta_n = 1'b0;
    tick();
    tick();
    compare("t5_no_vector", 8'(bus_if.data_out_en), 8'h00);
    bus_if.inta_n = 1'b1;
    tick();
    tick();

    $display("[TB] rotation scenario");
    apply_stimulus(8'h04, 8'h00, 1);
    run_ack(vec, clr, mid);
    compare("t6_vector2", vec, 8'h8A);
    send_eoi(1'b0, 3'd0);
    compare("t6_isr_clr", bus_if.Int_Serv_Reg, 8'h00);
    apply_stimulus(8'h05, 8'h00, 1);
    compare("t6_int_out", 8'(bus_if.int_out), 8'h01);
    run_ack(vec, clr, mid);
    compare("t6_vector0", vec, 8'h88);
    compare("t6_isr0",    mid, 8'h01);
`ifdef ROTATE_PRIORITY_EN
    compare("t6_pointer", 8'(dut.prio_ptr_q), 8'h02);
`endif
    send_eoi(1'b0, 3'd0);
    for (int i = 0; i < 4; i++) tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
